// File: rtl/reg_check_monitor.sv
// Register-file end-state checker: shadows DUT writebacks for a fixed window,
// then compares each shadow register against a preloaded expected table.
module reg_check_monitor #(
    parameter int          XLEN       = 32,
    parameter int          NUM_REGS   = 9,
    parameter int          RUN_CYCLES = 100,
    parameter logic [31:0] LINK_MASK  = 32'h0000_0042
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exp_we,
    input  logic [4:0]      exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic            start,
    input  logic            rf_we,
    input  logic [4:0]      rf_addr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            jump,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [5:0]      err_count,
    output logic [4:0]      first_err_idx,
    output logic [15:0]     jump_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CW        = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0]  CYC_LAST  = CW'(RUN_CYCLES - 1);
    localparam logic [4:0]     SCAN_LAST = 5'(NUM_REGS - 1);

    logic [1:0]    state;
    logic [CW-1:0] cyc;
    logic [4:0]    scan_idx;
    logic [31:0]   mm_vec;
    logic          idle_or_done, go, exp_wr_ok, rf_wr_ok, run_clear;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign go           = start && idle_or_done;
    assign exp_wr_ok    = !reset && exp_we && idle_or_done;
    assign rf_wr_ok     = !reset && rf_we && (state == S_RUN);
    assign run_clear    = reset || go;

    // One slot per architectural register; slots past NUM_REGS always match,
    // which lets the scan index the 32-bit mismatch vector with a full 5-bit index.
    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_live
            logic [XLEN-1:0] exp_q;
            logic [XLEN-1:0] sh_q;

            always_ff @(posedge clk) begin
                if (exp_wr_ok && exp_addr == 5'(i))
                    exp_q <= exp_data;
            end

            if (i == 0) begin : g_zero
                assign sh_q = '0;
            end else begin : g_shadow
                always_ff @(posedge clk) begin
                    if (run_clear)
                        sh_q <= '0;
                    else if (rf_wr_ok && rf_addr == 5'(i))
                        sh_q <= rf_wdata;
                end
            end

            // Link registers hold return addresses that vary run to run, so any
            // nonzero value counts as "was written".
            assign mm_vec[i] = !((sh_q == exp_q) || (LINK_MASK[i] && (sh_q != '0)));
        end else begin : g_pad
            assign mm_vec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cyc           <= '0;
            scan_idx      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            jump_count    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            busy <= (state == S_RUN) || (state == S_SCAN) || go;
            done <= (state == S_DONE) && !go;
            pass <= (state == S_DONE) && !go && (err_count == 6'd0);

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        cyc           <= '0;
                        scan_idx      <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        jump_count    <= '0;
                    end
                end
                S_RUN: begin
                    if (jump && jump_count != 16'hFFFF)
                        jump_count <= jump_count + 16'd1;
                    if (cyc == CYC_LAST) begin
                        state    <= S_SCAN;
                        scan_idx <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_SCAN: begin
                    if (mm_vec[scan_idx]) begin
                        if (err_count == 6'd0)
                            first_err_idx <= scan_idx;
                        if (err_count != 6'd63)
                            err_count <= err_count + 6'd1;
                    end
                    if (scan_idx == SCAN_LAST)
                        state <= S_DONE;
                    else
                        scan_idx <= scan_idx + 5'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench: default-size monitor plus a 32-register, 1-cycle-window
// instance sharing the same stimulus bus.
module tb_reg_check_monitor;

    logic        clk = 1'b0;
    logic        reset, exp_we, start, rf_we, jump;
    logic [4:0]  exp_addr, rf_addr;
    logic [31:0] exp_data, rf_wdata;

    logic        busy, done, pass;
    logic [5:0]  err_count;
    logic [4:0]  first_err_idx;
    logic [15:0] jump_count;

    logic        busy_b, done_b, pass_b;
    logic [5:0]  err_b;
    logic [4:0]  first_b;
    logic [15:0] jc_b;

    int nvec = 0, nerr = 0, tcount = 0, t0 = 0;

    always #5 clk = ~clk;

    reg_check_monitor dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .jump(jump),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .jump_count(jump_count)
    );

    reg_check_monitor #(.NUM_REGS(32), .RUN_CYCLES(1), .LINK_MASK(32'h0)) dut_big (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .jump(jump),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_idx(first_b), .jump_count(jc_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, tcount);
        end
    endtask

    task automatic load_exp(input int a, input logic [31:0] d);
        exp_we = 1'b1; exp_addr = 5'(a); exp_data = d;
        tick;
        exp_we = 1'b0;
    endtask

    task automatic rfw(input int a, input logic [31:0] d);
        rf_we = 1'b1; rf_addr = 5'(a); rf_wdata = d;
        tick;
        rf_we = 1'b0;
    endtask

    task automatic kick;
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = tcount;
    endtask

    task automatic wait_done(input string tag, input bit big, input int lat);
        while (((big ? done_b : done) == 1'b0) && (tcount - t0 < 400))
            tick;
        check({tag, ".latency"}, 32'(tcount - t0), 32'(lat));
    endtask

    task automatic check_res(input string tag, input logic p, input int e, input int f);
        check({tag, ".pass"}, {31'd0, pass}, {31'd0, p});
        check({tag, ".err"}, {26'd0, err_count}, 32'(e));
        check({tag, ".first"}, {27'd0, first_err_idx}, 32'(f));
    endtask

    task automatic std_writes(input logic [31:0] v2, input logic [31:0] v6, input bit w6,
                              input logic [31:0] v8);
        rfw(1, 32'h0C);
        rfw(2, v2);
        rfw(5, 32'h0A);
        if (w6) rfw(6, v6);
        rfw(8, v8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".pass"}, {31'd0, pass}, 32'd0);
        check({tag, ".err"}, {26'd0, err_count}, 32'd0);
        check({tag, ".first"}, {27'd0, first_err_idx}, 32'd0);
        check({tag, ".jumps"}, {16'd0, jump_count}, 32'd0);
    endtask

    logic [31:0] exp_tab [9] = '{32'h0, 32'h0C, 32'h5, 32'h0, 32'h0, 32'h0A, 32'h20, 32'h0, 32'h7};

    initial begin
        reset = 1'b1; exp_we = 1'b0; start = 1'b0; rf_we = 1'b0; jump = 1'b0;
        exp_addr = '0; exp_data = '0; rf_addr = '0; rf_wdata = '0;
        repeat (3) tick;
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) load_exp(i, exp_tab[i]);

        // all registers correct
        kick;
        check("run.busy", {31'd0, busy}, 32'd1);
        check("run.done", {31'd0, done}, 32'd0);
        std_writes(32'h5, 32'h20, 1'b1, 32'h7);
        wait_done("good", 1'b0, 110);
        check_res("good", 1'b1, 0, 0);
        check("good.busy", {31'd0, busy}, 32'd0);
        repeat (5) tick;
        check("hold.done", {31'd0, done}, 32'd1);
        check_res("hold", 1'b1, 0, 0);

        // link register with a different nonzero value
        kick;
        std_writes(32'h5, 32'h44, 1'b1, 32'h7);
        wait_done("link44", 1'b0, 110);
        check_res("link44", 1'b1, 0, 0);

        // link register never written
        kick;
        std_writes(32'h5, 32'h0, 1'b0, 32'h7);
        wait_done("link0", 1'b0, 110);
        check_res("link0", 1'b0, 1, 6);

        // two plain mismatches
        kick;
        std_writes(32'h4, 32'h20, 1'b1, 32'h9);
        wait_done("two", 1'b0, 110);
        check_res("two", 1'b0, 2, 2);

        // x0 / out-of-range writes, expected writes in RUN, writes and jump in SCAN
        kick;
        rfw(0, 32'hFFFF_FFFF);
        rfw(20, 32'h1234);
        load_exp(3, 32'h99);
        for (int j = 0; j < 3; j++) begin
            jump = 1'b1; tick; jump = 1'b0; tick;
        end
        std_writes(32'h5, 32'h20, 1'b1, 32'h7);
        while (tcount - t0 < 102) tick;
        rf_we = 1'b1; rf_addr = 5'd8; rf_wdata = 32'h0; jump = 1'b1;
        tick;
        rf_we = 1'b0; jump = 1'b0;
        wait_done("ignore", 1'b0, 110);
        check_res("ignore", 1'b1, 0, 0);
        check("ignore.jumps", {16'd0, jump_count}, 32'd3);

        // abort mid-RUN, then rerun with the retained expected table
        kick;
        rfw(3, 32'h55);
        jump = 1'b1; tick; jump = 1'b0;
        while (tcount - t0 < 50) tick;
        reset = 1'b1; tick; reset = 1'b0;
        check_zero("abort");
        repeat (3) tick;
        check("abort.idle", {31'd0, busy | done}, 32'd0);
        kick;
        std_writes(32'h5, 32'h20, 1'b1, 32'h7);
        wait_done("rerun", 1'b0, 110);
        check_res("rerun", 1'b1, 0, 0);

        // expected write coinciding with start from IDLE
        reset = 1'b1; tick; reset = 1'b0;
        exp_we = 1'b1; exp_addr = 5'd3; exp_data = 32'h33; start = 1'b1;
        tick;
        exp_we = 1'b0; start = 1'b0; t0 = tcount;
        std_writes(32'h5, 32'h20, 1'b1, 32'h7);
        rfw(3, 32'h33);
        wait_done("sameclk", 1'b0, 110);
        check_res("sameclk", 1'b1, 0, 0);

        // 32-register instance, nothing written: x0 matches, x1..x31 fail
        for (int i = 0; i < 32; i++) load_exp(i, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
        kick;
        wait_done("big", 1'b1, 34);
        check("big.err", {26'd0, err_b}, 32'd31);
        check("big.first", {27'd0, first_b}, 32'd1);
        check("big.pass", {31'd0, pass_b}, 32'd0);
        check("big.busy", {31'd0, busy_b}, 32'd0);

        // nonzero expected x0 makes every register fail
        load_exp(0, 32'h5);
        kick;
        wait_done("big_all", 1'b1, 34);
        check("big_all.err", {26'd0, err_b}, 32'd32);
        check("big_all.first", {27'd0, first_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
